// File: rtl/cdb_arbiter_pkg.sv
// ============================================================================
// cdb_arbiter_pkg : shared widths and CDB record types for the CDB arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package cdb_arbiter_pkg;

    localparam int XLEN          = 32;
    localparam int ROB_TAG_WIDTH = 3;

    typedef struct packed {
        logic [ROB_TAG_WIDTH-1:0] tag;
        logic [XLEN-1:0]          value;
    } cdb_req_t;

    typedef struct packed {
        logic                     valid;
        logic [ROB_TAG_WIDTH-1:0] tag;
        logic [XLEN-1:0]          value;
    } cdb_bus_t;

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, scanning upward from ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    localparam int SRC_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [SRC_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic [SRC_WIDTH-1:0] idx,
    output logic                 any
);

    logic [SRC_WIDTH:0]   pos_wide;
    logic [SRC_WIDTH-1:0] pos;

    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        pos_wide = '0;
        pos      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Wrap modulo NUM_REQ, which need not be a power of two
            pos_wide = {1'b0, ptr} + (SRC_WIDTH+1)'(k);
            if (pos_wide >= (SRC_WIDTH+1)'(NUM_REQ)) begin
                pos_wide = pos_wide - (SRC_WIDTH+1)'(NUM_REQ);
            end
            pos = pos_wide[SRC_WIDTH-1:0];
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// cdb_arbiter : one-deep hold slot per FU, round-robin onto a registered CDB
// Rev 1.0
// ============================================================================
`default_nettype none

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int TAG_WIDTH  = ROB_TAG_WIDTH,
    parameter  int DATA_WIDTH = XLEN,
    localparam int SRC_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall_i,
    input  logic                          flush_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_value_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          cdb_valid_o,
    output logic [TAG_WIDTH-1:0]          cdb_tag_o,
    output logic [DATA_WIDTH-1:0]         cdb_value_o,
    output logic [SRC_WIDTH-1:0]          cdb_src_o,
    output logic                          busy_o
);

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] value;
    } slot_t;

    typedef struct packed {
        logic                  valid;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] value;
        logic [SRC_WIDTH-1:0]  src;
    } bus_t;

    logic [NUM_REQ-1:0]   hold_v;
    slot_t                hold [NUM_REQ];
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   load;
    logic [SRC_WIDTH-1:0] rr_ptr;
    logic [SRC_WIDTH-1:0] win_idx;
    logic                 win_any;
    logic                 active;
    bus_t                 bus;

    assign active = !stall_i && !flush_i;

    // A slot being granted this cycle frees up in time to take a new result
    assign req_ready_o = {NUM_REQ{active}} & (~hold_v | grant);
    assign load        = req_valid_i & req_ready_o;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (hold_v),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_v <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                hold[i] <= '0;
            end
            bus    <= '0;
            rr_ptr <= '0;
        end else if (flush_i) begin
            hold_v    <= '0;
            bus.valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (!stall_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (load[i]) begin
                    hold_v[i] <= 1'b1;
                    hold[i]   <= '{tag:   req_tag_i[i*TAG_WIDTH +: TAG_WIDTH],
                                   value: req_value_i[i*DATA_WIDTH +: DATA_WIDTH]};
                end else if (grant[i]) begin
                    hold_v[i] <= 1'b0;
                end
            end
            if (win_any) begin
                bus.valid <= 1'b1;
                bus.tag   <= hold[win_idx].tag;
                bus.value <= hold[win_idx].value;
                bus.src   <= win_idx;
                rr_ptr    <= (win_idx == SRC_WIDTH'(NUM_REQ-1)) ? '0 : win_idx + SRC_WIDTH'(1);
            end else begin
                bus.valid <= 1'b0;
            end
        end
    end

    assign cdb_valid_o = bus.valid;
    assign cdb_tag_o   = bus.tag;
    assign cdb_value_o = bus.value;
    assign cdb_src_o   = bus.src;
    assign busy_o      = (|hold_v) | bus.valid;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// tb_cdb_arbiter : scoreboard bench with a queue-based reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 3;
    localparam int DW = 32;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic [N-1:0]      rv = '0;
    logic [N*TW-1:0]   rt = '0;
    logic [N*DW-1:0]   rval = '0;
    logic [N-1:0]      req_ready_o;
    logic              cdb_valid_o;
    logic [TW-1:0]     cdb_tag_o;
    logic [DW-1:0]     cdb_value_o;
    logic [SW-1:0]     cdb_src_o;
    logic              busy_o;

    cdb_arbiter #(.NUM_REQ(N), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall),
        .flush_i     (flush),
        .req_valid_i (rv),
        .req_tag_i   (rt),
        .req_value_i (rval),
        .req_ready_o (req_ready_o),
        .cdb_valid_o (cdb_valid_o),
        .cdb_tag_o   (cdb_tag_o),
        .cdb_value_o (cdb_value_o),
        .cdb_src_o   (cdb_src_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic [TW-1:0] tag;
        logic [DW-1:0] value;
        logic [SW-1:0] src;
    } bus_t;

    bus_t          exp_q[$];
    bus_t          m_bus;
    bit            m_held [N];
    logic [TW-1:0] m_tag  [N];
    logic [DW-1:0] m_val  [N];
    int            m_ptr;
    logic [TW-1:0] tag_in [N];
    logic [DW-1:0] val_in [N];
    int            vectors = 0;
    int            miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find_winner();
        for (int k = 0; k < N; k++) begin
            int p;
            p = (m_ptr + k) % N;
            if (m_held[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_held[i] = 1'b0;
        m_bus = '0;
        m_ptr = 0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            tag_in[i] = TW'($urandom);
            val_in[i] = $urandom;
        end
    endtask

    // One clock: drive at the falling edge, check ready/busy, predict the next edge
    task automatic step(input logic [N-1:0] v, input logic st, input logic fl);
        int           w;
        logic [N-1:0] exp_rdy;
        logic         exp_busy;
        @(negedge clk);
        rv    = v;
        stall = st;
        flush = fl;
        for (int i = 0; i < N; i++) begin
            rt[i*TW +: TW]   = tag_in[i];
            rval[i*DW +: DW] = val_in[i];
        end
        #1;
        w = (st || fl) ? -1 : find_winner();
        exp_busy = m_bus.valid;
        for (int i = 0; i < N; i++) begin
            exp_rdy[i] = !st && !fl && (!m_held[i] || i == w);
            if (m_held[i]) exp_busy = 1'b1;
        end
        check("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        check("busy", 64'(busy_o), 64'(exp_busy));
        if (fl) begin
            for (int i = 0; i < N; i++) m_held[i] = 1'b0;
            m_bus.valid = 1'b0;
            m_ptr = 0;
        end else if (!st) begin
            if (w >= 0) begin
                m_bus = '{valid: 1'b1, tag: m_tag[w], value: m_val[w], src: SW'(w)};
                m_held[w] = 1'b0;
                m_ptr = (w + 1) % N;
            end else begin
                m_bus.valid = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && exp_rdy[i]) begin
                    m_held[i] = 1'b1;
                    m_tag[i]  = tag_in[i];
                    m_val[i]  = val_in[i];
                end
            end
        end
        exp_q.push_back(m_bus);
    endtask

    // Asynchronous reset asserted mid-cycle; released just after a rising edge
    task automatic do_reset();
        @(negedge clk);
        rv    = '0;
        stall = 1'b0;
        flush = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_cdb_valid", 64'(cdb_valid_o), 64'(0));
        check("rst_cdb_tag", 64'(cdb_tag_o), 64'(0));
        check("rst_cdb_value", 64'(cdb_value_o), 64'(0));
        check("rst_cdb_src", 64'(cdb_src_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_ready", 64'(req_ready_o), 64'({N{1'b1}}));
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    // Monitor: every non-reset rising edge must match the next predicted bus state
    initial begin
        bus_t e;
        bus_t a;
        logic r;
        forever begin
            @(posedge clk);
            r = rst;
            #1;
            if (r) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL cdb_no_prediction: got valid=%0b expected a prediction at %0t",
                             cdb_valid_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    a = '{valid: cdb_valid_o, tag: cdb_tag_o, value: cdb_value_o, src: cdb_src_o};
                    check("cdb_bus", 64'(a), 64'(e));
                end
            end
        end
    end

    initial begin
        rand_data();
        do_reset();

        // Single request, FU2 tag 5 value 0xDEAD
        tag_in[2] = 3'd5;
        val_in[2] = 32'hDEAD;
        step(4'b0100, 1'b0, 1'b0);
        repeat (3) step(4'b0000, 1'b0, 1'b0);

        // Full contention from rr_ptr = 0
        do_reset();
        rand_data();
        step(4'b1111, 1'b0, 1'b0);
        repeat (5) step(4'b0000, 1'b0, 1'b0);

        // Steer rr_ptr to 3, then FU3 and FU0 offer continuously
        step(4'b0100, 1'b0, 1'b0);
        repeat (2) step(4'b0000, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            rand_data();
            step(4'b1001, 1'b0, 1'b0);
        end
        repeat (3) step(4'b0000, 1'b0, 1'b0);

        // Stall with two slots held
        rand_data();
        step(4'b0011, 1'b0, 1'b0);
        repeat (3) step(4'b1111, 1'b1, 1'b0);
        repeat (4) step(4'b0000, 1'b0, 1'b0);

        // Flush overriding stall with three slots held
        rand_data();
        step(4'b0111, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b1);
        repeat (3) step(4'b0000, 1'b0, 1'b0);

        // Reset mid-stream, then a fresh FU1 request
        rand_data();
        step(4'b0110, 1'b0, 1'b0);
        do_reset();
        rand_data();
        step(4'b0010, 1'b0, 1'b0);
        repeat (3) step(4'b0000, 1'b0, 1'b0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            rand_data();
            if (c == 300) do_reset();
            step(N'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 29) == 0));
        end
        repeat (2) step(4'b0000, 1'b0, 1'b0);

        @(posedge clk);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
